// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the reset PC, NOP encoding, FSM states and FIFO entry layout.
package if_fetch_pkg;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef logic [31:0] inst_t;
  typedef logic [63:0] inst_addr_t;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fifo_entry_t;

endpackage

// File: rtl/if_fetch_inst_fifo.sv
// Two-entry instruction buffer of {pc, inst} with push/pop/flush.
// Ports: clk, rst, flush_i, push_i, push_data_i, pop_i, head_o, count_o, empty_o.
module if_inst_fifo
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        push_i,
  input  fifo_entry_t push_data_i,
  input  logic        pop_i,
  output fifo_entry_t head_o,
  output logic [1:0]  count_o,
  output logic        empty_o
);

  fifo_entry_t mem_q [2];
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        full;
  logic        push_ok;
  logic        pop_ok;

  assign full    = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  // Push into a full buffer is only allowed when a pop frees a slot.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full || pop_ok);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = 1'b0;
      rd_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (push_ok) wr_d = ~wr_q;
      if (pop_ok)  rd_d = ~rd_q;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, one outstanding request, 2-entry buffer.
// Ports: clk/rst, EX redirect, ID hold, ifetch req/rsp handshake, inst head to ID.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [63:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic        ifetch_req_valid_o,
  input  logic        ifetch_req_ready_i,
  output logic [63:0] ifetch_addr_o,
  input  logic        ifetch_rsp_valid_i,
  input  logic [31:0] ifetch_rsp_data_i,
  output logic [31:0] inst_o,
  output logic [63:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  req_pc_q, req_pc_d;

  fifo_entry_t  head;
  fifo_entry_t  push_data;
  logic [1:0]   count;
  logic         empty;
  logic         pop;
  logic         push;
  logic         credit;
  logic         accept;
  logic [63:0]  jump_tgt;
  logic         unused_jump_lsb;

  assign unused_jump_lsb = ^jump_addr_i[1:0];
  assign jump_tgt        = {jump_addr_i[63:2], 2'b00};

  assign pop    = !empty && !hold_flag_i && !jump_flag_i;
  // In S_REQ nothing is outstanding, so credit is just buffer room
  // after this cycle's pop.
  assign credit = (count < DEPTH) || pop;
  assign accept = ifetch_req_valid_o && ifetch_req_ready_i;
  assign push   = (state_q == S_WAIT) && ifetch_rsp_valid_i && !jump_flag_i;

  assign ifetch_req_valid_o = !rst && (state_q == S_REQ) && credit;
  assign ifetch_addr_o      = rst ? RESET_PC : pc_q;

  assign push_data = '{pc: req_pc_q, inst: ifetch_rsp_data_i};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (accept) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + 64'd4;
    end
    if (jump_flag_i) pc_d = jump_tgt;
    unique case (state_q)
      S_REQ: begin
        if (accept) state_d = jump_flag_i ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (ifetch_rsp_valid_i) state_d = S_REQ;
        else if (jump_flag_i)   state_d = S_DROP;
      end
      S_DROP: begin
        if (ifetch_rsp_valid_i) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  if_inst_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (jump_flag_i),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .empty_o     (empty)
  );

  assign inst_valid_o = !empty;
  assign inst_o       = empty ? INST_NOP : head.inst;
  assign inst_addr_o  = empty ? 64'd0 : head.pc;

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch against a stream-level reference model.
// Memory model answers each accepted request after a 1..3 cycle latency.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i;
  logic [63:0] jump_addr_i;
  logic        hold_flag_i;
  logic        ifetch_req_valid_o;
  logic        ifetch_req_ready_i;
  logic [63:0] ifetch_addr_o;
  logic        ifetch_rsp_valid_i;
  logic [31:0] ifetch_rsp_data_i;
  logic [31:0] inst_o;
  logic [63:0] inst_addr_o;
  logic        inst_valid_o;

  int checks   = 0;
  int failures = 0;

  // memory model
  bit          pend;
  bit          pend_stale;
  int          pend_cnt;
  logic [63:0] pend_addr;
  int          lat_fix;

  // stream model
  int          occ;
  logic [63:0] exp_pop_pc;
  logic [63:0] exp_req_pc;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk                (clk),
    .rst                (rst),
    .jump_flag_i        (jump_flag_i),
    .jump_addr_i        (jump_addr_i),
    .hold_flag_i        (hold_flag_i),
    .ifetch_req_valid_o (ifetch_req_valid_o),
    .ifetch_req_ready_i (ifetch_req_ready_i),
    .ifetch_addr_o      (ifetch_addr_o),
    .ifetch_rsp_valid_i (ifetch_rsp_valid_i),
    .ifetch_rsp_data_i  (ifetch_rsp_data_i),
    .inst_o             (inst_o),
    .inst_addr_o        (inst_addr_o),
    .inst_valid_o       (inst_valid_o)
  );

  function automatic logic [31:0] mem_word(logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0513;
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check settled outputs, advance model.
  task automatic step(bit r, bit j, logic [63:0] ja, bit h, bit rdy, bit bad);
    bit          rsp_v;
    bit          exp_pop;
    bit          acc;
    bit          good_rsp;
    logic [63:0] tgt;
    rsp_v = !r && pend && (pend_cnt == 0);
    rst                = r;
    jump_flag_i        = j;
    jump_addr_i        = ja;
    hold_flag_i        = h;
    ifetch_req_ready_i = rdy;
    ifetch_rsp_valid_i = rsp_v;
    ifetch_rsp_data_i  = bad ? 32'hDEAD_BEEF : mem_word(pend_addr);
    #1;
    tgt = {ja[63:2], 2'b00};
    if (r) begin
      check("rst_req_valid", 64'(ifetch_req_valid_o), 64'd0);
      check("rst_req_addr", ifetch_addr_o, RESET_PC);
      pend       = 0;
      occ        = 0;
      exp_pop_pc = RESET_PC;
      exp_req_pc = RESET_PC;
    end else begin
      exp_pop = (occ > 0) && !h && !j;
      check("inst_valid", 64'(inst_valid_o), 64'(occ > 0));
      if (occ > 0) begin
        check("inst_addr", inst_addr_o, exp_pop_pc);
        check("inst_data", 64'(inst_o), 64'(mem_word(exp_pop_pc)));
      end else begin
        check("nop_inst", 64'(inst_o), 64'(INST_NOP));
        check("nop_addr", inst_addr_o, 64'd0);
      end
      check("req_valid", 64'(ifetch_req_valid_o),
            64'(!pend && (occ < 2 || exp_pop)));
      if (ifetch_req_valid_o) check("req_addr", ifetch_addr_o, exp_req_pc);
      acc      = ifetch_req_valid_o && rdy;
      good_rsp = rsp_v && !pend_stale && !j;
      if (rsp_v) pend = 0;
      else if (pend) pend_cnt--;
      if (j) pend_stale = 1;
      if (acc) begin
        pend       = 1;
        pend_stale = j;
        pend_addr  = ifetch_addr_o;
        pend_cnt   = (lat_fix > 0 ? lat_fix : 1 + int'($urandom_range(0, 2))) - 1;
      end
      if (j) begin
        occ        = 0;
        exp_pop_pc = tgt;
        exp_req_pc = tgt;
      end else begin
        occ = occ + int'(good_rsp) - int'(exp_pop);
        if (exp_pop) exp_pop_pc = exp_pop_pc + 64'd4;
        if (acc) exp_req_pc = exp_req_pc + 64'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(int n, bit h);
    for (int i = 0; i < n; i++) step(0, 0, 64'd0, h, 1, 0);
  endtask

  initial begin
    bit found;
    pend       = 0;
    pend_stale = 0;
    pend_cnt   = 0;
    pend_addr  = '0;
    occ        = 0;
    exp_pop_pc = RESET_PC;
    exp_req_pc = RESET_PC;
    lat_fix    = 1;
    @(negedge clk);
    step(1, 0, 64'd0, 0, 1, 0);
    step(1, 0, 64'd0, 0, 1, 0);

    // reset fetch and streaming, then hold fills buffer and drains
    idle(6, 0);
    idle(10, 1);
    check("hold_full_occ", 64'(occ), 64'd2);
    idle(6, 0);

    // redirect while waiting on a response
    lat_fix = 3;
    found   = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend && pend_cnt > 0) found = 1;
      else idle(1, 0);
    end
    check("wait_pending_found", 64'(found), 64'd1);
    step(0, 1, 64'h0000_0000_8000_0100, 0, 1, 0);
    idle(10, 0);

    // response in the redirect cycle carries poisoned data
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend && pend_cnt == 0) found = 1;
      else idle(1, 0);
    end
    check("same_cycle_found", 64'(found), 64'd1);
    step(0, 1, 64'h0000_0000_8000_0300, 0, 1, 1);
    check("flush_empty", 64'(inst_valid_o), 64'd0);
    idle(8, 0);

    // jump with hold and misaligned target
    lat_fix = 1;
    idle(6, 1);
    step(0, 1, 64'h0000_0000_8000_0203, 1, 1, 0);
    check("jh_empty", 64'(inst_valid_o), 64'd0);
    idle(8, 0);

    // reset while waiting with one buffered entry
    lat_fix = 2;
    found   = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (pend && occ == 1) found = 1;
      else idle(1, 1);
    end
    check("mid_rst_found", 64'(found), 64'd1);
    step(1, 0, 64'd0, 1, 1, 0);
    check("mid_rst_valid", 64'(inst_valid_o), 64'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 64'd0, 0, 0, 0);
    idle(6, 0);

    // PC wrap across 2^64
    lat_fix = 1;
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFF6, 0, 1, 0);
    idle(12, 0);

    // randomized traffic
    lat_fix = 0;
    for (int i = 0; i < 4000; i++) begin
      bit          r;
      bit          j;
      logic [63:0] ja;
      r  = ($urandom % 300) == 0;
      j  = ($urandom % 12) == 0;
      ja = (($urandom % 8) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom % 16)
                                 : 64'h8000_0000 + 64'($urandom % 4096);
      step(r, j, ja, ($urandom % 3) == 0, ($urandom % 4) != 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage for the RV64 NPC core. Owns the PC, issues fetch requests over a valid/ready instruction-memory port, and buffers returned instructions in a 2-entry FIFO. Presents `{inst, inst_addr}` to the combinational ID decoder, which consumes one entry per cycle unless ID raises its load-use hold. EX redirects (jumps and branches) flush the stage, and any stale in-flight response is discarded.

## Interface
Parameters:
- `RESET_PC`, default 64'h0000_0000_8000_0000: first fetch address after reset.
- `FIFO_DEPTH`, default 2: instruction buffer entries. Only 2 is supported.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `jump_flag_i` in 1: redirect request from EX.
- `jump_addr_i` in 64: redirect target; bits [1:0] are ignored and treated as 0.
- `hold_flag_i` in 1: ID load-use stall; the FIFO head is not consumed while it is high.
- `ifetch_req_valid_o` out 1: fetch request valid.
- `ifetch_req_ready_i` in 1: memory accepts the request.
- `ifetch_addr_o` out 64: fetch address.
- `ifetch_rsp_valid_i` in 1: response valid, single-cycle pulse.
- `ifetch_rsp_data_i` in 32: fetched instruction.
- `inst_o` out 32: FIFO head instruction; `INST_NOP` (32'h0000_0013) when the FIFO is empty.
- `inst_addr_o` out 64: FIFO head PC; 0 when the FIFO is empty.
- `inst_valid_o` out 1: FIFO not empty.

## Operation
- **Registers:**
  - `pc`: next address to request.
  - `req_pc`: address of the outstanding request.
  - `state`: one of `S_REQ`, `S_WAIT`, `S_DROP`.
  - FIFO of `{pc[63:0], inst[31:0]}` entries.
- **Outstanding requests:** at most one at any time.
- **Credit:** a request may be issued only when `fifo_count + outstanding < FIFO_DEPTH`. The pop in the current cycle is counted.
- **`S_REQ`:**
  - `ifetch_req_valid_o = credit`, `ifetch_addr_o = pc`.
  - On `valid && ready`: `req_pc <= pc`, `pc <= pc + 4`, go to `S_WAIT`.
  - Valid and address stay stable until accepted. The only exception is a redirect.
- **`S_WAIT`:** `ifetch_req_valid_o = 0`. On `ifetch_rsp_valid_i`: push `{req_pc, ifetch_rsp_data_i}`, go to `S_REQ`.
- **`S_DROP`:** `ifetch_req_valid_o = 0`. On `ifetch_rsp_valid_i`: discard the data, go to `S_REQ`.
- **Pop:** `inst_valid_o && !hold_flag_i`.
- **Redirect (`jump_flag_i = 1`), which overrides everything in the same cycle:**
  - FIFO is cleared; pop and push are suppressed.
  - `pc <= {jump_addr_i[63:2], 2'b00}`.
  - From `S_WAIT` with no response this cycle: go to `S_DROP`. Otherwise go to `S_REQ`.
  - A response arriving in the redirect cycle is discarded.
  - From `S_REQ`, any request accepted in the same cycle counts as stale, so the next state is `S_DROP`. Redirect in `S_DROP` keeps `S_DROP`.
- **Jump and hold in the same cycle:** jump wins.
- **Hold:** FIFO head and outputs are frozen. Requests continue while credit remains.
- **FIFO full:** no request is issued.
- **FIFO empty:** the NOP defaults on `inst_o`/`inst_addr_o` apply.
- **PC arithmetic:** wraps modulo 2^64.

## Timing
- **Reset values:**
  - `state = S_REQ`, `pc = RESET_PC`, FIFO empty.
  - `ifetch_req_valid_o = 0` during the reset cycle.
  - `ifetch_addr_o = RESET_PC`, `inst_valid_o = 0`, `inst_o = INST_NOP`, `inst_addr_o = 0`.
- **First request:** asserted in the first cycle after `rst` falls.
- **Reset mid-operation:** returns all state to reset values. A pending response is not tracked; the memory is reset together with the core.
- **Latency:** a response received in cycle N is visible on `inst_o` in cycle N+1.
- **Throughput:** one instruction per 2 cycles with zero-wait memory (request, then response).
- **Redirect latency:** new-target request appears in the cycle after the redirect, or one cycle after the stale response when in `S_DROP`.
- **Outputs:** all driven from registers (FIFO head and `state`). There is no combinational path from `ifetch_*_i` to `inst_*_o`.

## Structure
- **Add to `defines.v`:** `RESET_PC`, `INST_NOP` (32'h0000_0013), the state encodings, and reuse of `InstBus`/`InstAddrBus`.
- **Sub-module `if_inst_fifo`:**
  - 2-entry, 96-bit synchronous FIFO with push/pop/flush/count.
  - Flush takes priority over push and pop.
  - Simultaneous push and pop when full is legal.
  - Head is combinational from storage.

## Test plan
- **Reset fetch:** release `rst`, memory ready with 1-cycle response returning 32'h00000513 -> `ifetch_addr_o` = 0x8000_0000 in cycle 1; `inst_o` = 0x00000513 with `inst_addr_o` = 0x8000_0000 and `inst_valid_o` = 1 in cycle 3.
- **Hold fills FIFO:** hold high for 10 cycles -> exactly 2 entries buffered (0x8000_0000, 0x8000_0004), no request for 0x8000_0008 while full, head frozen; release -> entries drain in order.
- **Redirect in `S_WAIT`:** `jump_flag_i` with target 0x8000_0100 while a response is pending -> the next response is dropped (never on `inst_o`); the next request address is 0x8000_0100.
- **Redirect with response in the same cycle:** response data 0xDEADBEEF arrives together with `jump_flag_i` -> 0xDEADBEEF is never observed and the FIFO is empty the next cycle.
- **Jump plus hold, misaligned target:** `jump_flag_i` and `hold_flag_i` both high with target 0x8000_0203 -> FIFO flushed and the next request is to 0x8000_0200.
- **Reset mid-operation and backpressure:** assert `rst` in `S_WAIT` with FIFO holding 1 entry -> `inst_valid_o` = 0 and the next request is to `RESET_PC`. With `ifetch_req_ready_i` low for 5 cycles, `ifetch_addr_o` stays stable.
